// File: rtl/aes_pkg.sv
// Shared AES definitions for the iterative encryption core.
// Holds the FSM state codes, round-count constants, GF(2^8) helpers
// and the ShiftRows / MixColumns transforms on a 128-bit block.
// Byte 0 of a block is bits [127:120]; column c is bytes 4c..4c+3.
package aes_pkg;

    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned NR_AES192 = 12;
    localparam int unsigned NR_AES256 = 14;

    localparam int unsigned BLOCK_W   = 128;
    localparam int unsigned STATE_W   = 3;

    // FSM state codes (IDLE, SUB, MIX, LAST, DONE)
    typedef logic [STATE_W-1:0] state_t;
    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_SUB  = 3'd1;
    localparam logic [STATE_W-1:0] ST_MIX  = 3'd2;
    localparam logic [STATE_W-1:0] ST_LAST = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

    // Multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // General GF(2^8) product by shift-and-add over xtime
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[3'(i)]) begin
                acc = acc ^ x;
            end
            x = xtime(x);
        end
        return acc;
    endfunction

    // MSB position of byte idx within a block
    function automatic logic [6:0] byte_msb(input logic [3:0] idx);
        return 7'd127 - {idx, 3'b000};
    endfunction

    function automatic logic [7:0] get_byte(input logic [BLOCK_W-1:0] s, input logic [3:0] idx);
        return s[byte_msb(idx) -: 8];
    endfunction

    // Row r rotated left by r columns
    function automatic logic [BLOCK_W-1:0] shift_rows(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[byte_msb(4'(4 * c + row)) -: 8] = get_byte(s, 4'(4 * ((c + row) % 4) + row));
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [BLOCK_W-1:0] mix_columns(input logic [BLOCK_W-1:0] s);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[7'(127 - 32 * c) -: 32] = mix_column(s[7'(127 - 32 * c) -: 32]);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
// Ports: value   - input byte
//        subst_c - substituted byte (combinational)
// The multiplicative inverse is formed as value^254 by repeated squaring,
// which maps 0 to 0 as the S-box requires, then the affine map is applied.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] subst_c
);

    // a^254 = a^2 * a^4 * ... * a^128
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] acc;
        logic [7:0] sq;
        acc = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] inv;

    // Affine transform: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
    always_comb begin
        inv     = gf_inv(value);
        subst_c = inv
                ^ {inv[6:0], inv[7]}
                ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]}
                ^ 8'h63;
    end

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES encryption core with a single round datapath.
// Parameters: NR    - rounds (10/12/14)
//             LANES - S-box instances (4/8/16); a round's SubBytes takes 16/LANES cycles
// Ports: Clk, Rst (synchronous, active-high)
//        Start    - request, accepted in IDLE or DONE
//        PT       - plaintext, sampled on the accepting edge
//        RoundKey - key for KeyIdx, combinational from the external key store
//        KeyIdx   - requested round-key index
//        Busy     - high in SUB/MIX/LAST
//        Done     - one-cycle pulse, CT valid from this cycle
//        Ry       - high from Done until the next accepted Start
//        CT       - ciphertext register
module aes_iter_core
    import aes_pkg::*;
#(
    parameter int unsigned NR    = NR_AES128,
    parameter int unsigned LANES = 16
)(
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [127:0] PT,
    input  logic [127:0] RoundKey,
    output logic [3:0]   KeyIdx,
    output logic         Busy,
    output logic         Done,
    output logic         Ry,
    output logic [127:0] CT
);

    localparam int unsigned STEPS = 16 / LANES;
    localparam int unsigned SC_W  = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (NR != NR_AES128 && NR != NR_AES192 && NR != NR_AES256) begin : g_bad_nr
        $fatal(1, "aes_iter_core: NR must be 10, 12 or 14");
    end
    if (LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $fatal(1, "aes_iter_core: LANES must be 4, 8 or 16");
    end

    state_t             state_q, state_d;
    logic [3:0]         rnd_q, rnd_d;
    logic [SC_W-1:0]    sc_q, sc_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic [BLOCK_W-1:0] ct_d;
    logic               ry_d;
    logic               busy_d;
    logic               done_d;
    logic [3:0]         key_idx_d;
    logic               sc_last;

    logic [7:0] lane_in  [LANES];
    logic [7:0] lane_out [LANES];

    // Lane i works on byte sc*LANES+i during the current sub-step
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_in[i] = get_byte(data_q, 4'(sc_q * LANES + i));
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        aes_sbox u_sbox (
            .value   (lane_in[g]),
            .subst_c (lane_out[g])
        );
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        sc_d    = sc_q;
        data_d  = data_q;
        ct_d    = CT;
        ry_d    = Ry;
        sc_last = (sc_q == SC_W'(STEPS - 1));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    // KeyIdx is 0 here, so RoundKey is the whitening key
                    data_d  = PT ^ RoundKey;
                    rnd_d   = 4'd1;
                    sc_d    = '0;
                    ry_d    = 1'b0;
                    state_d = ST_SUB;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SUB: begin
                for (int i = 0; i < LANES; i++) begin
                    data_d[byte_msb(4'(sc_q * LANES + i)) -: 8] = lane_out[i];
                end
                if (sc_last) begin
                    sc_d    = '0;
                    state_d = (rnd_q < 4'(NR)) ? ST_MIX : ST_LAST;
                end else begin
                    sc_d    = sc_q + SC_W'(1);
                end
            end
            ST_MIX: begin
                data_d  = mix_columns(shift_rows(data_q)) ^ RoundKey;
                rnd_d   = rnd_q + 4'd1;
                sc_d    = '0;
                state_d = ST_SUB;
            end
            ST_LAST: begin
                // Final round has no MixColumns; result goes straight to CT
                ct_d    = shift_rows(data_q) ^ RoundKey;
                ry_d    = 1'b1;
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so derive them from the next state
        busy_d    = (state_d == ST_SUB) || (state_d == ST_MIX) || (state_d == ST_LAST);
        done_d    = (state_d == ST_DONE);
        key_idx_d = busy_d ? rnd_d : 4'd0;
    end

    // State, datapath and output registers
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            rnd_q   <= '0;
            sc_q    <= '0;
            data_q  <= '0;
            CT      <= '0;
            Ry      <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            KeyIdx  <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            sc_q    <= sc_d;
            data_q  <= data_d;
            CT      <= ct_d;
            Ry      <= ry_d;
            Busy    <= busy_d;
            Done    <= done_d;
            KeyIdx  <= key_idx_d;
        end
    end

endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core. Three instances run side by side:
// NR=10/LANES=16, NR=10/LANES=4 and NR=14/LANES=16, each with its own
// key store driven from a bench key expansion.
module tb_aes_iter_core;

    localparam int NI = 3;
    localparam int NR_I [NI] = '{10, 10, 14};
    localparam int ST_I [NI] = '{1, 4, 1};

    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] RK10   = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] P1     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] P2     = 128'hdeadbeef0123456789abcdeffedcba98;

    logic         Clk;
    logic         rst;
    logic         start [NI];
    logic [127:0] pt    [NI];
    logic [127:0] rkey  [NI];
    logic [3:0]   kidx  [NI];
    logic         busy  [NI];
    logic         done  [NI];
    logic         ry    [NI];
    logic [127:0] ct    [NI];

    logic [7:0]   sbox_t [256];
    logic [127:0] rk     [NI][16];

    int n_total = 0;
    int n_bad   = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    aes_iter_core #(.NR(10), .LANES(16)) u_dut0 (
        .Clk(Clk), .Rst(rst), .Start(start[0]), .PT(pt[0]), .RoundKey(rkey[0]),
        .KeyIdx(kidx[0]), .Busy(busy[0]), .Done(done[0]), .Ry(ry[0]), .CT(ct[0]));
    aes_iter_core #(.NR(10), .LANES(4)) u_dut1 (
        .Clk(Clk), .Rst(rst), .Start(start[1]), .PT(pt[1]), .RoundKey(rkey[1]),
        .KeyIdx(kidx[1]), .Busy(busy[1]), .Done(done[1]), .Ry(ry[1]), .CT(ct[1]));
    aes_iter_core #(.NR(14), .LANES(16)) u_dut2 (
        .Clk(Clk), .Rst(rst), .Start(start[2]), .PT(pt[2]), .RoundKey(rkey[2]),
        .KeyIdx(kidx[2]), .Busy(busy[2]), .Done(done[2]), .Ry(ry[2]), .CT(ct[2]));

    // Combinational key stores
    assign rkey[0] = rk[0][kidx[0]];
    assign rkey[1] = rk[1][kidx[1]];
    assign rkey[2] = rk[2][kidx[2]];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Carry-less product then reduction modulo 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    // S-box by brute-force inverse and the bitwise affine map
    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic expand_key(input int inst, input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [64];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t    = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk[inst][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
            else         rk[inst][r] = '0;
        end
    endtask

    // Reference encryption on a byte array
    function automatic logic [127:0] aes_enc(input int inst, input int nr, input logic [127:0] pin);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   mc [4];
        logic [7:0]   acc;
        logic [127:0] k, o;
        mc = '{8'h02, 8'h03, 8'h01, 8'h01};
        k  = rk[inst][0];
        for (int i = 0; i < 16; i++) b[i] = pin[127 - 8 * i -: 8] ^ k[127 - 8 * i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) b[i] = sbox_t[b[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4 * c + row] = b[4 * ((c + row) % 4) + row];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) begin
                    if (r < nr) begin
                        acc = 8'h00;
                        for (int q = 0; q < 4; q++) acc = acc ^ gmul(mc[(q - row + 4) % 4], t[4 * c + q]);
                        b[4 * c + row] = acc;
                    end else begin
                        b[4 * c + row] = t[4 * c + row];
                    end
                end
            k = rk[inst][r];
            for (int i = 0; i < 16; i++) b[i] = b[i] ^ k[127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = b[i];
        return o;
    endfunction

    // Behavioural model: a busy-cycle counter per instance
    int           cyc = 0;
    bit           model_on = 1'b0;
    int           mj      [NI];
    logic         m_done  [NI];
    logic         m_ry    [NI];
    logic [127:0] m_ct    [NI];
    logic [127:0] m_pend  [NI];
    int           acc_cyc [NI];

    always @(posedge Clk) begin : model
        int len;
        cyc++;
        for (int i = 0; i < NI; i++) begin
            len = NR_I[i] * (ST_I[i] + 1);
            if (rst) begin
                mj[i] = 0; m_done[i] = 1'b0; m_ry[i] = 1'b0; m_ct[i] = '0;
            end else if (mj[i] == len) begin
                mj[i] = 0; m_done[i] = 1'b1; m_ry[i] = 1'b1; m_ct[i] = m_pend[i];
            end else if (mj[i] > 0) begin
                mj[i]++; m_done[i] = 1'b0;
            end else begin
                m_done[i] = 1'b0;
                if (start[i]) begin
                    mj[i]      = 1;
                    m_ry[i]    = 1'b0;
                    m_pend[i]  = aes_enc(i, NR_I[i], pt[i]);
                    acc_cyc[i] = cyc;
                end
            end
        end
        if (rst) model_on = 1'b1;
    end

    // Compare process plus bookkeeping for the directed checks
    int           done_cnt  [NI] = '{0, 0, 0};
    int           busy_cnt  [NI] = '{0, 0, 0};
    int           lat       [NI] = '{0, 0, 0};
    int           gap       [NI] = '{0, 0, 0};
    int           prev_done [NI] = '{0, 0, 0};
    logic [127:0] last_ct   [NI];

    always @(negedge Clk) begin
        if (model_on) begin
            for (int i = 0; i < NI; i++) begin
                check($sformatf("busy%0d", i), 128'(busy[i]), 128'(mj[i] > 0));
                check($sformatf("keyidx%0d", i), 128'(kidx[i]),
                      128'((mj[i] > 0) ? ((mj[i] - 1) / (ST_I[i] + 1) + 1) : 0));
                check($sformatf("done%0d", i), 128'(done[i]), 128'(m_done[i]));
                check($sformatf("ry%0d", i), 128'(ry[i]), 128'(m_ry[i]));
                check($sformatf("ct%0d", i), ct[i], m_ct[i]);
                if (busy[i] === 1'b1) busy_cnt[i]++;
                if (done[i] === 1'b1) begin
                    done_cnt[i]++;
                    lat[i]       = cyc - acc_cyc[i];
                    gap[i]       = cyc - prev_done[i];
                    prev_done[i] = cyc;
                    last_ct[i]   = ct[i];
                end
            end
        end
    end

    task automatic wait_done(input int i, input int target, input int bound);
        int n;
        n = 0;
        while (done_cnt[i] < target && n < bound) begin
            @(negedge Clk); #1;
            n++;
        end
        check($sformatf("done_within_bound%0d", i), 128'(done_cnt[i] >= target), 128'(1));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin start[i] = 1'b0; pt[i] = '0; end

        build_sbox();
        expand_key(0, KEY128, 4, 10);
        expand_key(1, KEY128, 4, 10);
        expand_key(2, KEY256, 8, 14);

        // Pin the model to published values
        check("sbox_00", 128'(sbox_t[8'h00]), 128'h63);
        check("sbox_53", 128'(sbox_t[8'h53]), 128'hed);
        check("rk10_c1", rk[0][10], RK10);
        check("model_c1", aes_enc(0, 10, PT_C1), CT_C1);
        check("model_c3", aes_enc(2, 14, PT_C1), CT_C3);

        // Reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk); #1;
        check("rst_ct", ct[0], 128'h0);
        check("rst_kidx", 128'(kidx[0]), 128'h0);
        check("rst_ry", 128'(ry[1]), 128'h0);
        rst = 1'b0;

        // C.1 / C.1 with 4 lanes / C.3, all started together
        @(negedge Clk);
        for (int i = 0; i < NI; i++) begin start[i] = 1'b1; pt[i] = PT_C1; end
        busy_cnt[1] = 0;
        @(posedge Clk); #1;
        for (int i = 0; i < NI; i++) start[i] = 1'b0;
        wait_done(1, 1, 80);
        check("lat_c1_l16", 128'(lat[0]), 128'd20);
        check("lat_c1_l4", 128'(lat[1]), 128'd50);
        check("lat_c3", 128'(lat[2]), 128'd28);
        check("ct_c1_l16", last_ct[0], CT_C1);
        check("ct_c1_l4", last_ct[1], CT_C1);
        check("ct_c3", last_ct[2], CT_C3);
        check("busy_cycles_l4", 128'(busy_cnt[1]), 128'd50);

        // Start held high for three blocks
        @(negedge Clk);
        base = done_cnt[0];
        pt[0] = PT_C1; start[0] = 1'b1;
        @(posedge Clk); #1 pt[0] = P1;
        wait_done(0, base + 1, 40);
        check("b2b_ct0", ct[0], CT_C1);
        @(posedge Clk); #1 pt[0] = P2;
        check("b2b_ry_drop", 128'(ry[0]), 128'h0);
        wait_done(0, base + 2, 40);
        check("b2b_ct1", ct[0], aes_enc(0, 10, P1));
        check("b2b_gap1", 128'(gap[0]), 128'd21);
        @(posedge Clk); #1 pt[0] = PT_C1;
        wait_done(0, base + 3, 40);
        start[0] = 1'b0;
        check("b2b_ct2", ct[0], aes_enc(0, 10, P2));
        check("b2b_gap2", 128'(gap[0]), 128'd21);

        // Start pulse while busy is ignored
        @(negedge Clk);
        base = done_cnt[1];
        pt[1] = PT_C1; start[1] = 1'b1;
        @(posedge Clk); #1 begin start[1] = 1'b0; pt[1] = P1; end
        repeat (10) @(posedge Clk);
        #1 start[1] = 1'b1;
        @(posedge Clk); #1 start[1] = 1'b0;
        wait_done(1, base + 1, 80);
        check("busy_ignore_ct", ct[1], CT_C1);
        check("busy_ignore_lat", 128'(lat[1]), 128'd50);
        repeat (60) @(posedge Clk);
        #1 check("busy_ignore_single", 128'(done_cnt[1]), 128'(base + 1));

        // Reset mid-operation
        @(negedge Clk);
        base = done_cnt[0];
        pt[0] = PT_C1; start[0] = 1'b1;
        @(posedge Clk); #1 start[0] = 1'b0;
        repeat (6) @(posedge Clk);
        @(negedge Clk) rst = 1'b1;
        @(posedge Clk); #1;
        check("abort_kidx", 128'(kidx[0]), 128'h0);
        check("abort_busy", 128'(busy[0]), 128'h0);
        check("abort_done", 128'(done[0]), 128'h0);
        check("abort_ry", 128'(ry[0]), 128'h0);
        check("abort_ct", ct[0], 128'h0);
        @(negedge Clk) rst = 1'b0;
        repeat (40) @(posedge Clk);
        #1 check("abort_no_done", 128'(done_cnt[0]), 128'(base));
        @(negedge Clk);
        pt[0] = PT_C1; start[0] = 1'b1;
        @(posedge Clk); #1 begin start[0] = 1'b0; pt[0] = '0; end
        wait_done(0, base + 1, 40);
        check("post_abort_ct", ct[0], CT_C1);
        check("post_abort_lat", 128'(lat[0]), 128'd20);

        // Ry and CT hold while idle; Ry drops on the accepting edge
        for (int n = 0; n < 100; n++) begin
            @(negedge Clk); #1;
            check("idle_ry", 128'(ry[0]), 128'h1);
            check("idle_ct", ct[0], CT_C1);
        end
        pt[0] = P1; start[0] = 1'b1;
        check("ry_before_start", 128'(ry[0]), 128'h1);
        @(posedge Clk); #1 start[0] = 1'b0;
        check("ry_after_start", 128'(ry[0]), 128'h0);
        wait_done(0, base + 2, 40);
        check("final_ct", ct[0], aes_enc(0, 10, P1));

        repeat (3) @(posedge Clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
